mipi_csi_packet_decoder: RTL

Single-lane MIPI CSI-2 packet decoder placed directly downstream of the byte aligner. It consumes aligned bytes and their valid flag, and parses the 4-byte packet header (DI, WC_L, WC_H, ECC). It recovers frame/line short packets and forwards long-packet payload bytes to the pixel unpacker. At every packet end, and on any error, it drives the aligner's research-offset request so the aligner hunts for the next sync byte.

---
 rtl/mipi_csi_packet_decoder_if.sv | 8 +
 rtl/mipi_csi_packet_decoder.sv | 135 +++++++++++++
 2 files changed

// File: rtl/mipi_csi_packet_decoder_if.sv
// Aligned byte stream from the byte aligner into the CSI-2 packet decoder.
interface mipi_csi_packet_decoder_if;
  logic [7:0] I_Mipi_Byte_Data;
  logic       I_Mipi_Byte_Vaild;

  modport master (output I_Mipi_Byte_Data, output I_Mipi_Byte_Vaild);
  modport slave  (input  I_Mipi_Byte_Data, input  I_Mipi_Byte_Vaild);
endinterface

// File: rtl/mipi_csi_packet_decoder.sv
// Single-lane CSI-2 packet decoder: parses the 4-byte header, emits FS/FE pulses,
// forwards long-packet payload and asks the aligner to re-hunt sync after every packet.
module mipi_csi_packet_decoder #(
  parameter logic [1:0]  VC_SELECT     = 2'd0,
  parameter logic [15:0] MAX_WC        = 16'd5120,
  parameter int          RESEARCH_HOLD = 4
) (
  input  logic                              I_CLK,
  input  logic                              I_Rst_n,
  mipi_csi_packet_decoder_if.slave          bus,
  output logic                              O_ReSearch_Offset,
  output logic                              O_Frame_Start,
  output logic                              O_Frame_End,
  output logic                              O_Line_Valid,
  output logic [7:0]                        O_Payload_Data,
  output logic                              O_Payload_Vaild,
  output logic                              O_Payload_Last,
  output logic [5:0]                        O_Data_Type,
  output logic [1:0]                        O_Virtual_Channel,
  output logic [15:0]                       O_Word_Count,
  output logic                              O_Packet_Error
);

  typedef enum logic [3:0] {
    S_IDLE, S_HDR_WCL, S_HDR_WCH, S_HDR_ECC, S_PAYLOAD,
    S_CRC_L, S_CRC_H, S_RESYNC, S_WAIT_LOW
  } state_t;

  state_t      r_state, w_next;
  logic [7:0]  r_di, r_wcl, r_wch;
  logic [15:0] r_cnt;
  logic [3:0]  r_hold;

  logic [7:0]  w_byte;
  logic        w_vld;
  logic [5:0]  w_dt;
  logic [1:0]  w_vc;
  logic [15:0] w_wc;
  logic        w_vc_match, w_short, w_in_pkt, w_abort, w_hdr_done, w_take;
  logic        w_fs, w_fe, w_err, w_pay_vld, w_pay_last;

  assign w_byte     = bus.I_Mipi_Byte_Data;
  assign w_vld      = bus.I_Mipi_Byte_Vaild;
  assign w_dt       = r_di[5:0];
  assign w_vc       = r_di[7:6];
  assign w_wc       = {r_wch, r_wcl};
  assign w_vc_match = (w_vc == VC_SELECT);
  assign w_short    = (w_dt < 6'h10);

  always_ff @(posedge I_CLK or negedge I_Rst_n) begin
    if (!I_Rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_vld) w_next = S_HDR_WCL;
      S_HDR_WCL: w_next = w_vld ? S_HDR_WCH : S_RESYNC;
      S_HDR_WCH: w_next = w_vld ? S_HDR_ECC : S_RESYNC;
      S_HDR_ECC: begin
        if (!w_vld || w_short || (w_wc > MAX_WC)) w_next = S_RESYNC;
        else if (w_wc == 16'd0)                  w_next = S_CRC_L;
        else                                     w_next = S_PAYLOAD;
      end
      S_PAYLOAD: begin
        if (!w_vld)               w_next = S_RESYNC;
        else if (r_cnt == 16'd1)  w_next = S_CRC_L;
      end
      S_CRC_L:   w_next = w_vld ? S_CRC_H : S_RESYNC;
      S_CRC_H:   w_next = S_RESYNC;
      S_RESYNC:  if (r_hold == 4'(RESEARCH_HOLD - 1)) w_next = S_WAIT_LOW;
      // Stale bytes still flagged valid after the packet must not become a DI.
      S_WAIT_LOW: if (!w_vld) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_in_pkt   = (r_state == S_HDR_WCL) || (r_state == S_HDR_WCH) ||
                 (r_state == S_HDR_ECC) || (r_state == S_PAYLOAD) ||
                 (r_state == S_CRC_L)   || (r_state == S_CRC_H);
    w_abort    = w_in_pkt && !w_vld;
    w_hdr_done = (r_state == S_HDR_ECC) && w_vld;
    w_take     = (r_state == S_PAYLOAD) && w_vld;
    w_fs       = w_hdr_done && w_short && w_vc_match && (w_dt == 6'h00);
    w_fe       = w_hdr_done && w_short && w_vc_match && (w_dt == 6'h01);
    w_err      = w_abort || (w_hdr_done && !w_short && (w_wc > MAX_WC));
    w_pay_vld  = w_take && w_vc_match;
    w_pay_last = w_pay_vld && (r_cnt == 16'd1);
  end

  always_ff @(posedge I_CLK or negedge I_Rst_n) begin
    if (!I_Rst_n) begin
      r_di              <= '0;
      r_wcl             <= '0;
      r_wch             <= '0;
      r_cnt             <= '0;
      r_hold            <= '0;
      O_ReSearch_Offset <= 1'b0;
      O_Frame_Start     <= 1'b0;
      O_Frame_End       <= 1'b0;
      O_Line_Valid      <= 1'b0;
      O_Payload_Data    <= '0;
      O_Payload_Vaild   <= 1'b0;
      O_Payload_Last    <= 1'b0;
      O_Data_Type       <= '0;
      O_Virtual_Channel <= '0;
      O_Word_Count      <= '0;
      O_Packet_Error    <= 1'b0;
    end else begin
      if ((r_state == S_IDLE) && w_vld)    r_di  <= w_byte;
      if ((r_state == S_HDR_WCL) && w_vld) r_wcl <= w_byte;
      if ((r_state == S_HDR_WCH) && w_vld) r_wch <= w_byte;
      if (w_hdr_done) begin
        O_Data_Type       <= w_dt;
        O_Virtual_Channel <= w_vc;
        if (!w_short) O_Word_Count <= w_wc;
      end
      if (w_hdr_done)  r_cnt <= w_wc;
      else if (w_take) r_cnt <= r_cnt - 16'd1;
      r_hold <= (r_state == S_RESYNC) ? r_hold + 4'd1 : 4'd0;
      if (w_pay_vld) O_Payload_Data <= w_byte;
      // Line_Valid tracks the strobe, so it drops the cycle after Last or on abort.
      O_Payload_Vaild   <= w_pay_vld;
      O_Payload_Last    <= w_pay_last;
      O_Line_Valid      <= w_pay_vld;
      O_Frame_Start     <= w_fs;
      O_Frame_End       <= w_fe;
      O_Packet_Error    <= w_err;
      O_ReSearch_Offset <= (w_next == S_RESYNC);
    end
  end

endmodule
